// File: rtl/paddle_pkg.sv
// Shared types and defaults for the multi-channel paddle window generator.
package paddle_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } pad_state_t;

    localparam int PAD_LINES_DEF = 15;
    localparam int OFFSET_DEF    = 21;
    localparam int MIN_DLY_DEF   = 38;
    localparam int MAX_DLY_DEF   = 261;

    // Saturate v into [lo, hi].
    function automatic int unsigned clamp_u(input int unsigned v,
                                            input int unsigned lo,
                                            input int unsigned hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/paddle_chan.sv
// One paddle channel: one-shot delay from vblank, then a PAD_LINES-tall
// window with line index. All state moves only on line ticks.
// Optional PADDLE_FILTER_EN: IIR smoothing of the position at each load.
module paddle_chan
    import paddle_pkg::*;
#(
    parameter int POS_W     = 8,
    parameter int LINE_W    = 9,
    parameter int PAD_LINES = PAD_LINES_DEF,
    parameter int OFFSET    = OFFSET_DEF,
    parameter int MIN_DLY   = MIN_DLY_DEF,
    parameter int MAX_DLY   = MAX_DLY_DEF
) (
    input  logic             clk,
    input  logic             _reset,
    input  logic             tick,
    input  logic             v256_s,
    input  logic [POS_W-1:0] pos,
    output logic [3:0]       pad_idx,
    output logic             _vpad
);

    localparam int               SUM_W    = LINE_W + 1;
    localparam int               FW       = POS_W + 2;
    localparam logic [3:0]       IDX_LAST = 4'(PAD_LINES - 1);
    localparam logic [LINE_W-1:0] CNT_ONE = LINE_W'(1);

    pad_state_t        state;
    logic [LINE_W-1:0] cnt;
    logic [3:0]        idx;
    logic [POS_W-1:0]  pos_eff;
    logic [SUM_W-1:0]  dly_sum;
    logic [LINE_W-1:0] dly;
    logic              load;

    assign load = tick && (state == IDLE) && !v256_s;

`ifdef PADDLE_FILTER_EN
    logic [FW-1:0]        pos_f;
    logic [FW-1:0]        pos_f_nxt;
    logic signed [FW:0]   f_diff;

    // Next filtered value: pos_f + ((pos*4 - pos_f) >>> 2), signed.
    always_comb begin
        f_diff    = $signed({1'b0, pos, 2'b00}) - $signed({1'b0, pos_f});
        pos_f_nxt = pos_f + FW'(f_diff >>> 2);
        pos_eff   = pos_f_nxt[FW-1:2];
    end

    // Filter state only advances when a frame is loaded.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset)   pos_f <= '0;
        else if (load) pos_f <= pos_f_nxt;
    end
`else
    assign pos_eff = pos;
`endif

    // Sum is one bit wider than the counter so max position cannot wrap.
    assign dly_sum = SUM_W'(pos_eff) + SUM_W'(OFFSET);
    assign dly     = LINE_W'(clamp_u(32'(dly_sum), 32'(MIN_DLY), 32'(MAX_DLY)));

    // Channel FSM: IDLE -> DELAY (count D ticks) -> ACTIVE -> DONE -> IDLE.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else if (tick) begin
            case (state)
                IDLE: if (!v256_s) begin
                    cnt   <= dly;
                    state <= DELAY;
                end
                DELAY: if (cnt == CNT_ONE) begin
                    state <= ACTIVE;
                    idx   <= '0;
                end else begin
                    cnt <= cnt - CNT_ONE;
                end
                ACTIVE: if (idx == IDX_LAST) state <= DONE;
                        else                 idx   <= idx + 4'd1;
                // Stays here for the rest of vblank so one frame gives one window.
                DONE: if (v256_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so reset forces them at once.
    always_comb begin
        _vpad   = 1'b1;
        pad_idx = '0;
        case (state)
            ACTIVE: begin
                _vpad   = 1'b0;
                pad_idx = idx;
            end
            DONE:    pad_idx = IDX_LAST;
            default: ;
        endcase
    end

endmodule

// File: rtl/paddle_array.sv
// Multi-channel paddle vertical window generator. Synchronises _hsync and
// _v256, derives a one-cycle line_tick per _hsync fall, and drives NUM_CH
// independent paddle_chan instances. Optional feature macro: PADDLE_FILTER_EN.
module paddle_array
    import paddle_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int POS_W     = 8,
    parameter int LINE_W    = 9,
    parameter int PAD_LINES = PAD_LINES_DEF,
    parameter int OFFSET    = OFFSET_DEF,
    parameter int MIN_DLY   = MIN_DLY_DEF,
    parameter int MAX_DLY   = MAX_DLY_DEF
) (
    input  logic                    clk,
    input  logic                    _reset,
    input  logic                    _hsync,
    input  logic                    _v256,
    input  logic [NUM_CH*POS_W-1:0] paddle_vpos,
    output logic [NUM_CH*4-1:0]     pad_idx,
    output logic [NUM_CH-1:0]       _vpad,
    output logic                    line_tick
);

    logic [1:0] hs_sync;
    logic [1:0] v_sync;
    logic       hs_prev;

    // Two-flop synchronisers preset high so reset release sees no edge;
    // line_tick is the registered falling-edge detect of synced _hsync.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            hs_sync   <= 2'b11;
            v_sync    <= 2'b11;
            hs_prev   <= 1'b1;
            line_tick <= 1'b0;
        end else begin
            hs_sync   <= {hs_sync[0], _hsync};
            v_sync    <= {v_sync[0], _v256};
            hs_prev   <= hs_sync[1];
            line_tick <= hs_prev & ~hs_sync[1];
        end
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        paddle_chan #(
            .POS_W    (POS_W),
            .LINE_W   (LINE_W),
            .PAD_LINES(PAD_LINES),
            .OFFSET   (OFFSET),
            .MIN_DLY  (MIN_DLY),
            .MAX_DLY  (MAX_DLY)
        ) u_chan (
            .clk    (clk),
            ._reset (_reset),
            .tick   (line_tick),
            .v256_s (v_sync[1]),
            .pos    (paddle_vpos[n*POS_W +: POS_W]),
            .pad_idx(pad_idx[n*4 +: 4]),
            ._vpad  (_vpad[n])
        );
    end

endmodule

// File: tb/tb_paddle_array.sv
// Bench for paddle_array: directed frames plus randomized frames, checked
// against a line-count model of the paddle timing.
module tb_paddle_array;

    localparam int NCH = 2;
    localparam int PW  = 8;
    localparam int VW  = NCH * PW;
    localparam int P   = 15;

    logic          clk = 1'b0;
    logic          _reset;
    logic          _hsync;
    logic          _v256;
    logic [VW-1:0] paddle_vpos;
    logic [NCH*4-1:0] pad_idx;
    logic [NCH-1:0]   _vpad;
    logic          line_tick;

    paddle_array dut (
        .clk        (clk),
        ._reset     (_reset),
        ._hsync     (_hsync),
        ._v256      (_v256),
        .paddle_vpos(paddle_vpos),
        .pad_idx    (pad_idx),
        ._vpad      (_vpad),
        .line_tick  (line_tick)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: a channel is "armed" from its load tick until the first tick
    // with _v256 high after its window has finished.
    int tick_n = 0;
    int m_armed [NCH];
    int m_e0    [NCH];
    int m_d     [NCH];
    int m_pf    [NCH];
    int f_e0    [NCH];
    int f_d     [NCH];
    int fl      [NCH];
    int lowcnt  [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int clampd(input int v);
        if (v < 38)  return 38;
        if (v > 261) return 261;
        return v;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_armed[ch] = 0;
            m_pf[ch]    = 0;
        end
    endtask

    task automatic model_tick(input logic v, input logic [VW-1:0] pv);
        int p;
        int eff;
        tick_n++;
        for (int ch = 0; ch < NCH; ch++) begin
            p = int'(pv[ch*PW +: PW]);
            if (m_armed[ch] == 0) begin
                if (v == 1'b0) begin
`ifdef PADDLE_FILTER_EN
                    m_pf[ch] = m_pf[ch] + ((p * 4 - m_pf[ch]) >>> 2);
                    eff      = m_pf[ch] / 4;
`else
                    eff      = p;
`endif
                    m_armed[ch] = 1;
                    m_e0[ch]    = tick_n;
                    m_d[ch]     = clampd(eff + 21);
                    f_e0[ch]    = tick_n;
                    f_d[ch]     = m_d[ch];
                end
            end else if (v == 1'b1 && (tick_n - m_e0[ch]) > m_d[ch] + P) begin
                m_armed[ch] = 0;
            end
        end
    endtask

    task automatic exp_out(input int ch, output int ev, output int ei);
        int k;
        ev = 1; ei = 0;
        if (m_armed[ch] != 0) begin
            k = tick_n - m_e0[ch];
            if (k >= m_d[ch] + P)   ei = P - 1;
            else if (k >= m_d[ch]) begin ev = 0; ei = k - m_d[ch]; end
        end
    endtask

    // One video line: _hsync low for 3 clocks, high for 3; the tick must
    // appear exactly on the third clock.
    task automatic run_line(input logic v, input logic [VW-1:0] pv);
        int ev, ei;
        _v256 = v; paddle_vpos = pv; _hsync = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            chk("line_tick", line_tick, (i == 3));
            if (i == 3) _hsync = 1'b1;
        end
        model_tick(v, pv);
        for (int ch = 0; ch < NCH; ch++) begin
            exp_out(ch, ev, ei);
            chk($sformatf("vpad%0d@%0d", ch, tick_n), _vpad[ch], ev);
            chk($sformatf("idx%0d@%0d", ch, tick_n), pad_idx[ch*4 +: 4], ei);
            if (_vpad[ch] === 1'b0) begin
                lowcnt[ch]++;
                if (fl[ch] < 0) fl[ch] = tick_n;
            end
        end
    endtask

    // Frame: hi_pre lines high, lo_n lines low, then high until every
    // channel is back to idle (bounded).
    task automatic run_frame(input int hi_pre, input int lo_n,
                             input logic [VW-1:0] pv, input bit jitter);
        logic [VW-1:0] cur;
        int l;
        bit busy;
        for (int ch = 0; ch < NCH; ch++) begin fl[ch] = -1; lowcnt[ch] = 0; end
        cur = pv;
        l = 0;
        busy = 1;
        while (busy && l < hi_pre + lo_n + 400) begin
            if (jitter && l > hi_pre) cur = VW'($urandom);
            run_line((l >= hi_pre && l < hi_pre + lo_n) ? 1'b0 : 1'b1, cur);
            l++;
            busy = (l < hi_pre + lo_n);
            for (int ch = 0; ch < NCH; ch++) if (m_armed[ch] != 0) busy = 1;
        end
        chk("frame_bound", busy, 1'b0);
        for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("fall_off%0d", ch), fl[ch] - f_e0[ch], f_d[ch]);
            chk($sformatf("win_len%0d", ch), lowcnt[ch], P);
        end
    endtask

    task automatic do_reset();
        _reset = 1'b0;
        #1;
        chk("rst_vpad", _vpad, 2'b11);
        chk("rst_idx", pad_idx, 8'h00);
        chk("rst_tick", line_tick, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        _reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_f [3];
        _reset = 1'b1; _hsync = 1'b1; _v256 = 1'b1; paddle_vpos = '0;
        model_reset();

        // 1: reset, release with _hsync idle high, no ticks for 10 clocks.
        #2;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_tick", line_tick, 1'b0);
            chk("idle_vpad", _vpad, 2'b11);
            chk("idle_idx", pad_idx, 8'h00);
        end

        // 2: pos 100 on both channels, _v256 low for several lines.
        run_frame(2, 5, {8'd100, 8'd100}, 1'b0);
`ifndef PADDLE_FILTER_EN
        chk("d_pos100", f_d[0], 121);
`endif

        // 3: clamp limits.
        run_frame(1, 3, {8'd255, 8'd0}, 1'b0);
`ifndef PADDLE_FILTER_EN
        chk("d_min", fl[0] - f_e0[0], 38);
        chk("d_max", fl[1] - f_e0[1], 261);
`endif

        // 4: _v256 held low well past the window: still only one window.
        run_frame(1, 71 + P + 17, {8'd50, 8'd50}, 1'b1);
        run_frame(1, 1, {8'd50, 8'd50}, 1'b0);

        // 5: reset at idx 7 of an active window, then a normal frame.
        for (int ch = 0; ch < NCH; ch++) begin fl[ch] = -1; lowcnt[ch] = 0; end
        run_line(1'b1, {8'd100, 8'd100});
        run_line(1'b0, {8'd100, 8'd100});
        for (int i = 0; i < m_d[0] + 7; i++) run_line(1'b1, {8'd100, 8'd100});
        chk("mid_idx7", pad_idx[3:0], 4'd7);
        chk("mid_vpad", _vpad[0], 1'b0);
        do_reset();
        run_frame(2, 2, {8'd100, 8'd20}, 1'b0);

        // Random frames with positions jittering after the load.
        for (int f = 0; f < 4; f++)
            run_frame($urandom_range(1, 3), $urandom_range(1, 20), VW'($urandom), 1'b1);

`ifdef PADDLE_FILTER_EN
        // 6: filter step response from reset.
        exp_f[0] = 71; exp_f[1] = 108; exp_f[2] = 136;
        do_reset();
        for (int f = 0; f < 3; f++) begin
            run_frame(1, 2, {8'd200, 8'd200}, 1'b0);
            chk($sformatf("filt_d%0d", f), fl[0] - f_e0[0], exp_f[f]);
        end
`else
        exp_f[0] = 0; exp_f[1] = 0; exp_f[2] = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/paddle_array.md
Name: paddle_array

Overview:
- Parametrised multi-channel successor to the single-paddle vertical window generator.
- Fully synchronous to one system clock; _hsync and _v256 are sampled, not used as clocks.
- Per channel: emulates the 555 one-shot delay from vblank, then a PAD_LINES-tall paddle window with line index.
- Sits between the input/paddle-position front end and the video/hit-detect logic; one instance serves all players.

Parameters:
- NUM_CH, 2, number of paddle channels.
- POS_W, 8, width of each position input.
- LINE_W, 9, width of the delay counter.
- PAD_LINES, 15, paddle height in lines (1..16).
- OFFSET, 21, lines added to the position: 5 post-256 lines + 16 vblank lines.
- MIN_DLY, 38, lower clamp on the delay.
- MAX_DLY, 261, upper clamp on the delay.

Ports:
- clk  in  1  system clock.
- _reset  in  1  asynchronous, active-low reset.
- _hsync  in  1  horizontal sync, active low, asynchronous to clk.
- _v256  in  1  low during vertical blank/retrace.
- paddle_vpos  in  NUM_CH*POS_W  packed positions; channel n is bits [n*POS_W +: POS_W].
- pad_idx  out  NUM_CH*4  per-channel line index within the paddle window (old a,b,c,d).
- _vpad  out  NUM_CH  per-channel paddle window, active low.
- line_tick  out  1  one-cycle pulse per detected _hsync falling edge.

Behaviour:
- Reset (async assert, sync release):
  - all channels IDLE; counters 0.
  - pad_idx = 0, _vpad = all 1, line_tick = 0.
  - sync flops preset to 1 (no false edge at release).
- Line tick:
  - _hsync and _v256 each pass through a 2-flop synchroniser.
  - line_tick = sync_hs_prev & ~sync_hs; it is registered.
  - All channel state advances only on cycles with line_tick = 1.
  - Latency: line_tick is high on the 3rd clk edge after the first edge sampling _hsync low.
  - Channel outputs update on the clk edge following line_tick.
- Delay: D = clamp(pos + OFFSET, MIN_DLY, MAX_DLY).
  - Computed at LINE_W+1 bits, so no wrap for pos up to 2^POS_W-1.
- Per-channel FSM (evaluated on tick only):
  - IDLE: if sync _v256 = 0, then cnt <= D and go to DELAY. The position is sampled here only.
  - DELAY: if cnt = 1, go to ACTIVE with idx <= 0; else cnt <= cnt-1.
  - ACTIVE: _vpad = 0. If idx = PAD_LINES-1, go to DONE; else idx <= idx+1.
  - DONE: _vpad = 1. Go to IDLE when sync _v256 = 1. This blocks re-triggering within the same vblank.
- Timing: with the load at tick E0, _vpad is low for ticks E0+D .. E0+D+PAD_LINES-1 inclusive.
- pad_idx:
  - holds idx during ACTIVE.
  - holds PAD_LINES-1 in DONE.
  - is 0 in IDLE and DELAY.
- _v256 low during DELAY/ACTIVE: ignored.
- _v256 high before DELAY completes: ignored; the sequence continues.
- Position changes after the load have no effect until the next frame.
- Channels are independent; identical positions give identical outputs on the same cycle.
- Reset mid-operation: immediate return to reset values; no partial window.

Optional Feature:
- Macro: PADDLE_FILTER_EN.
- Defined:
  - each channel keeps pos_f (POS_W+2 bits, reset 0).
  - at each IDLE load: pos_f <= pos_f + ((pos<<2) - pos_f) >>> 2, using signed arithmetic.
  - D uses pos_f>>2 in place of pos. This removes pot jitter.
- Undefined: the raw position is used; no extra registers.

Decomposition:
- Package paddle_pkg holds:
  - state enum pad_state_t {IDLE, DELAY, ACTIVE, DONE}.
  - default constants PAD_LINES_DEF, OFFSET_DEF, MIN_DLY_DEF, MAX_DLY_DEF.
  - a clamp function.
- Sub-module paddle_chan: one channel (FSM, counter, clamp, optional filter), instantiated NUM_CH times via generate.
- Top level holds the synchronisers and the line_tick generator.

Test Plan:
1. Reset held, then released with _hsync idle high -> _vpad = 2'b11, pad_idx = 0, no line_tick for 10 clk.
2. pos0 = 100, _v256 low at tick E0 -> D = 121; _vpad[0] low ticks E0+121..E0+135; pad_idx[0] counts 0..14; then DONE.
3. pos = 0 and pos = 255 -> D clamps to 38 and 261; _vpad falls at E0+38 and E0+261 respectively.
4. _v256 held low 16 ticks after DONE -> no second window; window recurs only after _v256 goes high then low.
5. _reset pulsed low mid-ACTIVE (idx = 7) -> _vpad = 1, pad_idx = 0 immediately; next frame gives a normal window.
6. PADDLE_FILTER_EN, pos steps 0 -> 200 -> loads give pos_f>>2 of 50, 87, 115 on successive frames (D = 71, 108, 136).
